// File: rtl/mem_wb_stage.sv
// Elastic MEM/WB stage register: merges MEM-stage exceptions into the beat and
// buffers it behind a valid/ready handshake. Define MEM_WB_SKID_EN for the two-entry skid buffer.
module mem_wb_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_ADDR_W     = 5,
  parameter int unsigned EXP_W          = 3,
  parameter int unsigned EXP_NONE       = 0,
  parameter int unsigned EXP_MISS_ALIGN = 1,
  parameter int unsigned EXP_BUS_ERR    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W-1:0]      ex_exp_code,
  input  logic [DATA_W-1:0]     ex_pc,
  input  logic                  ex_en,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_gpr_we_,
  input  logic [DATA_W-1:0]     out,
  input  logic                  miss_align,
  input  logic                  bus_err,
  input  logic                  flush,
  input  logic                  wb_ready,
  output logic                  mem_valid,
  output logic [EXP_W-1:0]      mem_exp_code,
  output logic [DATA_W-1:0]     mem_pc,
  output logic                  mem_en,
  output logic [REG_ADDR_W-1:0] mem_rd_addr,
  output logic                  mem_gpr_we_,
  output logic [DATA_W-1:0]     mem_out
);

  typedef struct packed {
    logic [EXP_W-1:0]      exp_code;
    logic [DATA_W-1:0]     pc;
    logic                  en;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  gpr_we_;
    logic [DATA_W-1:0]     data;
  } beat_t;

  localparam logic [EXP_W-1:0] CODE_NONE  = EXP_W'(EXP_NONE);
  localparam logic [EXP_W-1:0] CODE_ALIGN = EXP_W'(EXP_MISS_ALIGN);
  localparam logic [EXP_W-1:0] CODE_BUS   = EXP_W'(EXP_BUS_ERR);
  localparam beat_t RESET_BEAT = '{exp_code: CODE_NONE, pc: '0, en: 1'b0,
                                   rd_addr: '0, gpr_we_: 1'b1, data: '0};

`ifdef MEM_WB_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
  beat_t skid_q, skid_d;
  logic  in_ready_q;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_e;
`endif

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  in_beat;
  logic   accept, consume;

  // An exception from an earlier stage wins; a MEM-raised one kills the write-back.
  always_comb begin
    in_beat = '{exp_code: ex_exp_code, pc: ex_pc, en: ex_en,
                rd_addr: ex_rd_addr, gpr_we_: ex_gpr_we_, data: out};
    if (ex_exp_code == CODE_NONE && (bus_err || miss_align)) begin
      in_beat.exp_code = bus_err ? CODE_BUS : CODE_ALIGN;
      in_beat.rd_addr  = '0;
      in_beat.gpr_we_  = 1'b1;
      in_beat.data     = '0;
    end
  end

`ifdef MEM_WB_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = (state_q == EMPTY) || wb_ready;
`endif

  assign accept  = in_valid && in_ready;
  assign consume = (state_q != EMPTY) && wb_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef MEM_WB_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_BEAT;
`ifdef MEM_WB_SKID_EN
      skid_d  = RESET_BEAT;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_beat;
`ifdef MEM_WB_SKID_EN
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = FULL;
`endif
          end else if (consume) begin
            main_d  = RESET_BEAT;
            state_d = EMPTY;
          end
        end
`ifdef MEM_WB_SKID_EN
        FULL: begin
          if (consume) begin
            main_d  = skid_q;
            skid_d  = RESET_BEAT;
            state_d = ONE;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          main_d  = RESET_BEAT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= RESET_BEAT;
`ifdef MEM_WB_SKID_EN
      skid_q     <= RESET_BEAT;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
`ifdef MEM_WB_SKID_EN
      skid_q     <= skid_d;
      // Registered so in_ready never depends combinationally on wb_ready.
      in_ready_q <= (state_d != FULL);
`endif
    end
  end

  assign mem_valid    = (state_q != EMPTY);
  assign mem_exp_code = main_q.exp_code;
  assign mem_pc       = main_q.pc;
  assign mem_en       = main_q.en;
  assign mem_rd_addr  = main_q.rd_addr;
  assign mem_gpr_we_  = main_q.gpr_we_;
  assign mem_out      = main_q.data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: queue-based reference model compared every
// cycle, plus directed literal checks. Honours MEM_WB_SKID_EN like the design.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ex_exp_code;
  logic [31:0] ex_pc;
  logic        ex_en;
  logic [4:0]  ex_rd_addr;
  logic        ex_gpr_we_;
  logic [31:0] out_data;
  logic        miss_align;
  logic        bus_err;
  logic        flush;
  logic        wb_ready;
  logic        mem_valid;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_pc;
  logic        mem_en;
  logic [4:0]  mem_rd_addr;
  logic        mem_gpr_we_;
  logic [31:0] mem_out;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ex_exp_code(ex_exp_code), .ex_pc(ex_pc), .ex_en(ex_en),
    .ex_rd_addr(ex_rd_addr), .ex_gpr_we_(ex_gpr_we_), .out(out_data),
    .miss_align(miss_align), .bus_err(bus_err), .flush(flush),
    .wb_ready(wb_ready), .mem_valid(mem_valid), .mem_exp_code(mem_exp_code),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_rd_addr(mem_rd_addr),
    .mem_gpr_we_(mem_gpr_we_), .mem_out(mem_out)
  );

  typedef struct {
    logic [2:0]  code;
    logic [31:0] pc;
    logic        en;
    logic [4:0]  rd;
    logic        we_;
    logic [31:0] data;
  } mbeat_t;

  mbeat_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // What the stage must hold if the current inputs are accepted.
  function automatic mbeat_t formed();
    mbeat_t b;
    b.code = ex_exp_code; b.pc = ex_pc; b.en = ex_en;
    b.rd = ex_rd_addr; b.we_ = ex_gpr_we_; b.data = out_data;
    if (ex_exp_code == 3'd0 && (bus_err || miss_align)) begin
      b.code = bus_err ? 3'd2 : 3'd1;
      b.rd = 5'd0; b.we_ = 1'b1; b.data = 32'd0;
    end
    return b;
  endfunction

  function automatic bit exp_ready();
`ifdef MEM_WB_SKID_EN
    return mq.size() < 2;
`else
    return mq.size() == 0 || wb_ready;
`endif
  endfunction

  always @(posedge clk) begin : model_upd
    bit acc, con;
    acc = in_valid && exp_ready();
    con = (mq.size() > 0) && wb_ready;
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back(formed());
    end
  end

  always @(negedge clk) begin : compare
    mbeat_t e;
    if (check_en) begin
      e = '{code: 3'd0, pc: 32'd0, en: 1'b0, rd: 5'd0, we_: 1'b1, data: 32'd0};
      if (mq.size() > 0) e = mq[0];
      chk("m_valid", 32'(mem_valid), 32'(mq.size() > 0));
      chk("m_ready", 32'(in_ready), 32'(exp_ready()));
      chk("m_code", 32'(mem_exp_code), 32'(e.code));
      chk("m_pc", mem_pc, e.pc);
      chk("m_en", 32'(mem_en), 32'(e.en));
      chk("m_rd", 32'(mem_rd_addr), 32'(e.rd));
      chk("m_we", 32'(mem_gpr_we_), 32'(e.we_));
      chk("m_out", mem_out, e.data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; bus_err = 1'b0; miss_align = 1'b0;
    ex_exp_code = 3'd0;
  endtask

  task automatic set_beat(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
    in_valid = 1'b1; ex_pc = pc; ex_rd_addr = rd; out_data = d;
    ex_en = 1'b1; ex_gpr_we_ = 1'b0; ex_exp_code = 3'd0;
    bus_err = 1'b0; miss_align = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_reset_fields(input string tag);
    chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_we"}, 32'(mem_gpr_we_), 32'd1);
    chk({tag, "_pc"}, mem_pc, 32'd0);
    chk({tag, "_out"}, mem_out, 32'd0);
    chk({tag, "_code"}, 32'(mem_exp_code), 32'd0);
    chk({tag, "_rd"}, 32'(mem_rd_addr), 32'd0);
    chk({tag, "_en"}, 32'(mem_en), 32'd0);
  endtask

  initial begin
    reset = 1'b1; wb_ready = 1'b1;
    ex_pc = 32'd0; ex_en = 1'b0; ex_rd_addr = 5'd0; ex_gpr_we_ = 1'b1; out_data = 32'd0;
    idle();
    tick();
    check_en = 1'b1;
    tick();
    chk_reset_fields("rst");
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Streaming: one beat per cycle, visible one cycle after accept.
    for (int i = 0; i < 8; i++) begin
      set_beat(32'h100 + 32'(4 * i), 5'(i + 1), $urandom);
      wb_ready = 1'b1;
      tick();
      chk("str_valid", 32'(mem_valid), 32'd1);
      chk("str_pc", mem_pc, 32'h100 + 32'(4 * i));
      chk("str_ready", 32'(in_ready), 32'd1);
    end
    idle();
    tick();
    chk("str_drain", 32'(mem_valid), 32'd0);

    // Back-pressure.
    wb_ready = 1'b0;
    set_beat(32'h300, 5'd3, 32'h3);
    tick();
    chk("bp_pc0", mem_pc, 32'h300);
`ifdef MEM_WB_SKID_EN
    chk("bp_ready1", 32'(in_ready), 32'd1);
    set_beat(32'h304, 5'd4, 32'h4);
    tick();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_pc_hold", mem_pc, 32'h300);
    set_beat(32'h308, 5'd5, 32'h5);
    tick();
    chk("bp_pc_hold2", mem_pc, 32'h300);
    wb_ready = 1'b1;
    tick();
    chk("bp_pc1", mem_pc, 32'h304);
    tick();
    chk("bp_pc2", mem_pc, 32'h308);
`else
    chk("bp_ready_lo", 32'(in_ready), 32'd0);
    wb_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    wb_ready = 1'b0;
    set_beat(32'h304, 5'd4, 32'h4);
    tick();
    tick();
    chk("bp_pc_hold", mem_pc, 32'h300);
    wb_ready = 1'b1;
    tick();
    chk("bp_pc1", mem_pc, 32'h304);
`endif
    idle();
    tick();
    chk("bp_empty", 32'(mem_valid), 32'd0);

    // Exception priority.
    set_beat(32'h400, 5'd5, 32'h1234);
    ex_exp_code = 3'd3; miss_align = 1'b1;
    tick();
    chk("exc_early_code", 32'(mem_exp_code), 32'd3);
    chk("exc_early_rd", 32'(mem_rd_addr), 32'd5);
    chk("exc_early_we", 32'(mem_gpr_we_), 32'd0);
    set_beat(32'h404, 5'd7, 32'hdeadbeef);
    bus_err = 1'b1; miss_align = 1'b1;
    tick();
    chk("exc_bus_code", 32'(mem_exp_code), 32'd2);
    chk("exc_bus_rd", 32'(mem_rd_addr), 32'd0);
    chk("exc_bus_we", 32'(mem_gpr_we_), 32'd1);
    chk("exc_bus_out", mem_out, 32'd0);
    chk("exc_bus_pc", mem_pc, 32'h404);
    set_beat(32'h408, 5'd9, 32'h55);
    miss_align = 1'b1;
    tick();
    chk("exc_align_code", 32'(mem_exp_code), 32'd1);
    idle();
    tick();

    // Flush while the stage is full, with a beat arriving.
    wb_ready = 1'b0;
    set_beat(32'h500, 5'd1, 32'h50);
    tick();
    set_beat(32'h504, 5'd2, 32'h54);
    tick();
    set_beat(32'h508, 5'd3, 32'h58);
    flush = 1'b1;
    tick();
    chk_reset_fields("fl");
    chk("fl_ready", 32'(in_ready), 32'd1);
    idle();
    wb_ready = 1'b1;
    tick();
    chk("fl_dropped", 32'(mem_valid), 32'd0);

    // Reset with beats held.
    wb_ready = 1'b0;
    set_beat(32'h600, 5'd6, 32'h60);
    tick();
    set_beat(32'h604, 5'd7, 32'h64);
    tick();
    idle();
    reset = 1'b1;
    tick();
    chk_reset_fields("mrst");
    reset = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_valid    = ($urandom % 4) != 0;
      wb_ready    = ($urandom % 3) != 0;
      ex_pc       = $urandom;
      ex_en       = 1'($urandom);
      ex_rd_addr  = 5'($urandom);
      ex_gpr_we_  = 1'($urandom);
      out_data    = $urandom;
      ex_exp_code = (($urandom % 8) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      bus_err     = ($urandom % 10) == 0;
      miss_align  = ($urandom % 8) == 0;
      flush       = ($urandom % 40) == 0;
      reset       = ($urandom % 150) == 0;
      tick();
    end
    idle();
    reset = 1'b0;
    wb_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
